// File: rtl/cnt_down_pkg.sv
// Shared types and constants for the cnt_down_timer block.
package cnt_down_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned PS_W_DEFAULT = 8;

endpackage

// File: rtl/cnt_down_timer_prescaler.sv
// cnt_prescaler: tick generator that fires every Prescale+1 cycles.
// Only compiled when CNT_DOWN_PRESCALE_EN is defined.
`ifdef CNT_DOWN_PRESCALE_EN
module cnt_prescaler
  import cnt_down_pkg::*;
#(
  parameter int unsigned PS_W = PS_W_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Clr,
  input  logic [PS_W-1:0] Prescale,
  output logic            Tick
);

  logic [PS_W-1:0] cnt;

  assign Tick = (cnt == Prescale);

  // Wrap on the tick so the next tick is a full Prescale+1 cycles away
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (Clr || Tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PS_W'(1);
    end
  end

endmodule
`endif

// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer with one-shot Done pulse and sticky Irq.
// Optional tick prescaler enabled by CNT_DOWN_PRESCALE_EN.
module cnt_down_timer
  import cnt_down_pkg::*;
#(
  parameter int unsigned N = 32
`ifdef CNT_DOWN_PRESCALE_EN
  , parameter int unsigned PS_W = PS_W_DEFAULT
`endif
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Pwr_off,
  input  logic [N-1:0]    Load_val,
  input  logic            Start,
  input  logic            Stop,
  input  logic            Auto_reload,
  input  logic            Irq_clr,
`ifdef CNT_DOWN_PRESCALE_EN
  input  logic [PS_W-1:0] Prescale,
`endif
  output logic [N-1:0]    Vout,
  output logic            Busy,
  output logic            Done,
  output logic            Irq
);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   vout_nxt;
  logic           done_nxt;
  logic           irq_nxt;
  logic           tick;

`ifdef CNT_DOWN_PRESCALE_EN
  cnt_prescaler #(
    .PS_W(PS_W)
  ) u_prescaler (
    .Clk      (Clk),
    .Rst      (Rst),
    .Clr      (Pwr_off | Start | Stop),
    .Prescale (Prescale),
    .Tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign Busy = (state == RUN);

  // Register stage: state and all outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      Vout  <= '0;
      Done  <= 1'b0;
      Irq   <= 1'b0;
    end else begin
      state <= state_nxt;
      Vout  <= vout_nxt;
      Done  <= done_nxt;
      Irq   <= irq_nxt;
    end
  end

  // Next-state and next-output logic; priority Pwr_off > Stop > Start > count
  always_comb begin
    state_nxt = state;
    vout_nxt  = Vout;
    done_nxt  = 1'b0;

    if (Pwr_off) begin
      state_nxt = IDLE;
      vout_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!Stop && Start) begin
            if (Load_val != '0) begin
              vout_nxt  = Load_val;
              state_nxt = RUN;
            end else begin
              vout_nxt = '0;
              done_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (Stop) begin
            state_nxt = IDLE;
          end else if (Start) begin
            vout_nxt = Load_val;
          end else if (tick) begin
            if (Vout > N'(1)) begin
              vout_nxt = Vout - N'(1);
            end else begin
              done_nxt = 1'b1;
              if (Auto_reload && (Load_val != '0)) begin
                vout_nxt = Load_val;
              end else begin
                vout_nxt  = '0;
                state_nxt = IDLE;
              end
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          vout_nxt  = '0;
        end
      endcase
    end

    // Set beats clear on the same edge
    irq_nxt = Pwr_off ? 1'b0 : (done_nxt | (Irq & ~Irq_clr));
  end

endmodule

// File: tb/tb_cnt_down_timer.sv
// Directed, table-driven bench for cnt_down_timer with a few hand sequences.
module tb_cnt_down_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwr_off;
  logic [31:0] load_val;
  logic        start;
  logic        stop;
  logic        auto_reload;
  logic        irq_clr;
  logic [31:0] vout;
  logic        busy;
  logic        done;
  logic        irq;
`ifdef CNT_DOWN_PRESCALE_EN
  logic [7:0]  prescale;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        pwr_off;
    logic        auto_reload;
    logic        irq_clr;
    logic [31:0] load_val;
    logic [31:0] exp_vout;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  cnt_down_timer #(.N(32)) dut (
    .Clk         (clk),
    .Rst         (rst),
    .Pwr_off     (pwr_off),
    .Load_val    (load_val),
    .Start       (start),
    .Stop        (stop),
    .Auto_reload (auto_reload),
    .Irq_clr     (irq_clr),
`ifdef CNT_DOWN_PRESCALE_EN
    .Prescale    (prescale),
`endif
    .Vout        (vout),
    .Busy        (busy),
    .Done        (done),
    .Irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic add(input logic st, input logic sp, input logic po, input logic ar,
                     input logic ic, input logic [31:0] lv, input logic [31:0] ev,
                     input logic eb, input logic ed, input logic ei);
    vec_t v;
    v.start = st; v.stop = sp; v.pwr_off = po; v.auto_reload = ar; v.irq_clr = ic;
    v.load_val = lv; v.exp_vout = ev; v.exp_busy = eb; v.exp_done = ed; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] ev, input logic eb,
                         input logic ed, input logic ei);
    chk({nm, " vout"}, vout, ev);
    chk({nm, " busy"}, 32'(busy), 32'(eb));
    chk({nm, " done"}, 32'(done), 32'(ed));
    chk({nm, " irq"},  32'(irq),  32'(ei));
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; pwr_off = 0; auto_reload = 0; irq_clr = 0;
  endtask

  // Advance one edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load_val = '0;
    idle_inputs();
`ifdef CNT_DOWN_PRESCALE_EN
    prescale = '0;
`endif

    //   st sp po ar ic  load  vout busy done irq
    // one-shot, L=4
    add(1, 0, 0, 0, 0, 4,  4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4,  3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4,  0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 4,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 4,  0, 0, 0, 0);
    // periodic, L=3 then Load_val=2 taking effect at the next expiry
    add(1, 0, 0, 1, 0, 3,  3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 3,  2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 3,  1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 3,  3, 1, 1, 1);
    add(0, 0, 0, 1, 1, 2,  2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 2,  1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 2,  2, 1, 1, 1);
    add(0, 0, 0, 1, 0, 2,  1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 2,  2, 1, 1, 1);
    add(0, 0, 0, 1, 0, 2,  1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 2,  0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 2,  0, 0, 0, 0);
    // Start with Load_val=0
    add(1, 0, 0, 0, 0, 0,  0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0);
    // Start and Stop together in RUN: Stop wins
    add(1, 0, 0, 0, 0, 9,  9, 1, 0, 0);
    add(0, 0, 0, 0, 0, 9,  8, 1, 0, 0);
    add(1, 1, 0, 0, 0, 5,  8, 0, 0, 0);
    add(0, 0, 0, 0, 0, 5,  8, 0, 0, 0);
    // Start on an expiry edge: restart, no Done
    add(1, 0, 0, 0, 0, 2,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2,  1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 6,  6, 1, 0, 0);
    add(0, 0, 0, 0, 0, 6,  5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 6,  4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 6,  3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 6,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 6,  1, 1, 0, 0);
    // Irq_clr on the expiry edge: set wins
    add(0, 0, 0, 0, 1, 6,  0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 6,  0, 0, 0, 1);
    // Pwr_off in RUN at Vout=7 with Irq=1 overrides Start
    add(1, 0, 0, 0, 0, 8,  8, 1, 0, 1);
    add(0, 0, 0, 0, 0, 8,  7, 1, 0, 1);
    add(1, 0, 1, 0, 0, 3,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3,  0, 0, 0, 0);

    #12;
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start       = vecs[i].start;
      stop        = vecs[i].stop;
      pwr_off     = vecs[i].pwr_off;
      auto_reload = vecs[i].auto_reload;
      irq_clr     = vecs[i].irq_clr;
      load_val    = vecs[i].load_val;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].exp_vout, vecs[i].exp_busy,
              vecs[i].exp_done, vecs[i].exp_irq);
    end
    idle_inputs();

    // Async Rst mid-count at Vout=5 with Irq set clears outputs without an edge
    start = 1; load_val = 0; step();
    start = 1; load_val = 9; step();
    start = 0;
    for (int i = 0; i < 4; i++) step();
    chk_all("pre_rst", 5, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    #1;
    rst = 1'b0;

`ifdef CNT_DOWN_PRESCALE_EN
    // Prescale=2, L=2 -> Done 6 edges after Start; Prescale=0 -> 2 edges
    for (int p = 0; p < 2; p++) begin
      int exp_lat;
      int got_lat;
      prescale = (p == 0) ? 8'd2 : 8'd0;
      exp_lat  = (p == 0) ? 6 : 2;
      got_lat  = -1;
      @(negedge clk);
      start = 1; load_val = 2;
      step();
      start = 0;
      for (int c = 1; c <= 20; c++) begin
        step();
        if (done && got_lat < 0) got_lat = c;
      end
      chk($sformatf("prescale%0d latency", prescale), 32'(got_lat), 32'(exp_lat));
      irq_clr = 1; step(); irq_clr = 0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
